// File: rtl/cnn16_pingpong_ram.sv
// Ping-pong feature-map RAM: the producer fills one bank while the consumer drains the other.
// Bank ownership comes from per-bank full flags; done pulses seal or free a bank and swap sides.
module cnn16_pingpong_ram #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_wr_done,
  output logic                  o_wr_ready,
  output logic                  o_wr_bank,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic                  i_rd_done,
  output logic                  o_rd_ready,
  output logic                  o_rd_bank,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [1:0]            o_full_cnt,
  output logic                  o_err_wr,
  output logic                  o_err_rd
);

  localparam int unsigned Depth = 2 ** (ADDR_WIDTH + 1);

  // Both banks share one array; the bank index is the top address bit.
  logic [DATA_WIDTH-1:0] r_mem [Depth];

  logic [1:0]            r_full;
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_err_wr;
  logic                  r_err_rd;

  logic       w_wr_ready;
  logic       w_rd_ready;
  logic       w_wr_accept;
  logic       w_wr_seal;
  logic       w_rd_accept;
  logic       w_rd_free;
  logic [1:0] w_full_d;

  assign w_wr_ready  = ~r_full[r_wr_bank];
  assign w_rd_ready  = r_full[r_rd_bank];
  assign w_wr_accept = i_wr_en & w_wr_ready;
  assign w_wr_seal   = i_wr_done & w_wr_ready;
  assign w_rd_accept = i_rd_en & w_rd_ready;
  assign w_rd_free   = i_rd_done & w_rd_ready;

  // When both sides are ready they own different banks, so set and clear never collide.
  always_comb begin
    w_full_d = r_full;
    if (w_wr_seal) w_full_d[r_wr_bank] = 1'b1;
    if (w_rd_free) w_full_d[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_accept) r_mem[{r_wr_bank, i_wr_addr}] <= i_wr_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_full     <= 2'b00;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_err_wr   <= 1'b0;
      r_err_rd   <= 1'b0;
    end else begin
      r_full     <= w_full_d;
      r_rd_valid <= w_rd_accept;
      if (w_wr_seal) r_wr_bank <= ~r_wr_bank;
      if (w_rd_free) r_rd_bank <= ~r_rd_bank;
      if (w_rd_accept) r_rd_data <= r_mem[{r_rd_bank, i_rd_addr}];
      if ((i_wr_en | i_wr_done) & ~w_wr_ready) r_err_wr <= 1'b1;
      if ((i_rd_en | i_rd_done) & ~w_rd_ready) r_err_rd <= 1'b1;
    end
  end

  assign o_wr_ready = w_wr_ready;
  assign o_wr_bank  = r_wr_bank;
  assign o_rd_ready = w_rd_ready;
  assign o_rd_bank  = r_rd_bank;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_full_cnt = {1'b0, r_full[0]} + {1'b0, r_full[1]};
  assign o_err_wr   = r_err_wr;
  assign o_err_rd   = r_err_rd;

endmodule

// File: tb/tb_cnn16_pingpong_ram.sv
// Directed bench for cnn16_pingpong_ram: hand-computed expectations for bank swaps,
// registered reads, stall/error handling and asynchronous reset.
module tb_cnn16_pingpong_ram;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, wr_done, rd_en, rd_done;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready, wr_bank, rd_ready, rd_bank, rd_valid, err_wr, err_rd;
  logic [DW-1:0] rd_data;
  logic [1:0]    full_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cnn16_pingpong_ram #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_wr_done  (wr_done),
    .o_wr_ready (wr_ready),
    .o_wr_bank  (wr_bank),
    .i_rd_en    (rd_en),
    .i_rd_addr  (rd_addr),
    .i_rd_done  (rd_done),
    .o_rd_ready (rd_ready),
    .o_rd_bank  (rd_bank),
    .o_rd_valid (rd_valid),
    .o_rd_data  (rd_data),
    .o_full_cnt (full_cnt),
    .o_err_wr   (err_wr),
    .o_err_rd   (err_rd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_done = 1'b0; rd_en = 1'b0; rd_done = 1'b0;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    idle();
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_wr_ready"}, 32'(wr_ready), 32'd1);
    check({pfx, "_rd_ready"}, 32'(rd_ready), 32'd0);
    check({pfx, "_full_cnt"}, 32'(full_cnt), 32'd0);
    check({pfx, "_wr_bank"},  32'(wr_bank),  32'd0);
    check({pfx, "_rd_bank"},  32'(rd_bank),  32'd0);
    check({pfx, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({pfx, "_rd_data"},  32'(rd_data),  32'd0);
    check({pfx, "_err_wr"},   32'(err_wr),   32'd0);
    check({pfx, "_err_rd"},   32'(err_rd),   32'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    #2;
    check_reset_state("rst0");
    tick();
    rst = 1'b0;

    // Fill bank0 and seal it.
    for (int i = 0; i < 4; i++) write(AW'(i), DW'(16'h0A00 + i));
    wr_done = 1'b1; tick(); idle();
    check("seal0_wr_bank",  32'(wr_bank),  32'd1);
    check("seal0_rd_ready", 32'(rd_ready), 32'd1);
    check("seal0_full_cnt", 32'(full_cnt), 32'd1);
    check("seal0_wr_ready", 32'(wr_ready), 32'd1);

    // Registered read, then hold on idle.
    rd_en = 1'b1; rd_addr = 12'd2; tick(); idle();
    check("rd2_valid", 32'(rd_valid), 32'd1);
    check("rd2_data",  32'(rd_data),  32'h0A02);
    tick();
    check("idle_valid", 32'(rd_valid), 32'd0);
    check("idle_data",  32'(rd_data),  32'h0A02);

    // Fill and seal bank1 while the reader still owns bank0.
    write(12'd0, 16'hBEEF);
    wr_done = 1'b1; tick(); idle();
    check("both_full_cnt", 32'(full_cnt), 32'd2);
    check("both_wr_ready", 32'(wr_ready), 32'd0);
    check("both_wr_bank",  32'(wr_bank),  32'd0);

    // Stalled write must be dropped and flagged.
    write(12'd0, 16'h1234);
    check("stall_err_wr", 32'(err_wr), 32'd1);
    rd_en = 1'b1; rd_addr = 12'd0; tick(); idle();
    check("stall_mem_kept", 32'(rd_data), 32'h0A00);

    rd_done = 1'b1; tick(); idle();
    check("free0_wr_ready", 32'(wr_ready), 32'd1);
    check("free0_wr_bank",  32'(wr_bank),  32'd0);
    check("free0_rd_bank",  32'(rd_bank),  32'd1);
    check("free0_full_cnt", 32'(full_cnt), 32'd1);
    rd_en = 1'b1; rd_addr = 12'd0; tick(); idle();
    check("rd_b1_data", 32'(rd_data), 32'hBEEF);

    // Read and free bank1 in the same cycle.
    rd_en = 1'b1; rd_done = 1'b1; rd_addr = 12'd0; tick(); idle();
    check("rdfree_valid",    32'(rd_valid), 32'd1);
    check("rdfree_data",     32'(rd_data),  32'hBEEF);
    check("rdfree_rd_ready", 32'(rd_ready), 32'd0);
    check("rdfree_full_cnt", 32'(full_cnt), 32'd0);
    check("rdfree_err_rd",   32'(err_rd),   32'd0);
    rd_en = 1'b1; rd_addr = 12'd1; tick(); idle();
    check("badrd_valid",  32'(rd_valid), 32'd0);
    check("badrd_err_rd", 32'(err_rd),   32'd1);
    check("badrd_hold",   32'(rd_data),  32'hBEEF);

    // Reset clears sticky errors before the simultaneous-done case.
    rst = 1'b1; #1;
    check_reset_state("rst1");
    tick();
    rst = 1'b0;

    write(12'd0, 16'h5555);
    wr_done = 1'b1; tick(); idle();
    check("f01_full_cnt", 32'(full_cnt), 32'd1);
    wr_done = 1'b1; rd_done = 1'b1; tick(); idle();
    check("swap_wr_bank",  32'(wr_bank),  32'd0);
    check("swap_rd_bank",  32'(rd_bank),  32'd1);
    check("swap_full_cnt", 32'(full_cnt), 32'd1);
    check("swap_wr_ready", 32'(wr_ready), 32'd1);
    check("swap_rd_ready", 32'(rd_ready), 32'd1);
    check("swap_err_wr",   32'(err_wr),   32'd0);
    check("swap_err_rd",   32'(err_rd),   32'd0);

    // Mid-fill reset while a read of bank1 is in flight.
    wr_en = 1'b1; wr_addr = 12'd0; wr_data = 16'h7777;
    rd_en = 1'b1; rd_addr = 12'd0;
    tick();
    wr_addr = 12'd1; wr_data = 16'h7778;
    tick(); idle();
    check("pre_rst_valid", 32'(rd_valid), 32'd1);
    check("pre_rst_data",  32'(rd_data),  32'hBEEF);
    rst = 1'b1; #1;
    check_reset_state("rst2");
    tick();
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
